perf_event_monitor: RTL and testbench
=====================================

PERF_EVENT_MONITOR -- requirements
Module: perf_event_monitor

Interface
REQ-001 Parameter NUM_EV, default 4: number of event channels, 1..16.
REQ-002 Parameter CNT_W, default 32: width of every counter, 8..64.
REQ-003 Parameter SAT, default 0: counter overflow mode; 0 = wrap to zero, 1 = saturate at all-ones.
REQ-004 Parameter SEL_W, default 4: read-select width; the integrator shall set it so 2**SEL_W >= NUM_EV.
REQ-005 clk_i  in  1: the single clock; all state updates occur on its rising edge.
REQ-006 rst_i  in  1: asynchronous, active-low reset.
REQ-007 start_i  in  1: level-sensitive run enable.
REQ-008 clear_i  in  1: synchronous clear of all counters and flags.
REQ-009 event_i  in  NUM_EV: per-channel event strobes, one count per asserted cycle (e.g. stall, flush).
REQ-010 limit_i  in  CNT_W: cycle limit; 0 = unlimited.
REQ-011 rd_sel_i  in  SEL_W: selects the event counter for readout.
REQ-012 rd_data_o  out  CNT_W: registered readout of the selected counter.
REQ-013 cycle_o  out  CNT_W: count of cycles spent in RUN.
REQ-014 running_o  out  1: high while the state is RUN.
REQ-015 done_o  out  1: high while the state is DONE.
REQ-016 ovf_o  out  NUM_EV: sticky per-channel overflow flags.

Function
REQ-017 The block shall implement the states IDLE, RUN and DONE; running_o and done_o decode directly from the state register.
REQ-018 IDLE: if start_i=1, go to RUN at the next edge; the counters do not change on that edge.
REQ-019 RUN:
- each edge increments cycle_o by 1;
- each edge increments counter k by 1 for every event_i[k]=1.
REQ-020 RUN with start_i=0: go to IDLE (pause) at the next edge; no counting on that edge; counts are retained for a later resume.
REQ-021 RUN with limit_i != 0: on the edge where cycle_o would become limit_i, counting occurs and the state goes to DONE; that cycle's events are counted.
REQ-022 DONE: all counters and ovf_o are frozen; start_i is ignored; only clear_i or reset leaves DONE.
REQ-023 clear_i=1 on any edge:
- zeroes cycle_o, every event counter and ovf_o;
- sets the state to IDLE;
- overrides start_i, events and limit on the same edge.
REQ-024 Overflow, event counter at all-ones with its event asserted in RUN:
- SAT=0: the counter wraps to 0;
- SAT=1: the counter holds all-ones;
- both modes: ovf_o[k] is set and stays set until clear or reset.
REQ-025 cycle_o follows the same wrap or saturate rule but has no overflow flag.
REQ-026 rd_data_o is updated every edge, including in IDLE and DONE, to the pre-update value of counter[rd_sel_i]; latency is 1 cycle.
REQ-027 rd_data_o shall be 0 when rd_sel_i >= NUM_EV.
REQ-028 Changing limit_i mid-RUN to a value <= cycle_o shall not trigger DONE; the cycle count must equal the limit exactly.

Reset
REQ-029 rst_i=0 shall immediately, independent of clk_i, force:
- state IDLE;
- all counters, cycle_o and rd_data_o to 0;
- ovf_o to 0, running_o to 0, done_o to 0.
REQ-030 Reset asserted mid-RUN or in DONE discards all counts; after rst_i rises, operation resumes from IDLE.

Verification
REQ-031 rst_i low with start_i=1, limit_i=30, event_i[0]=1 constant -> running_o=1 one edge after rst_i rises; done_o=1 after 30 counting edges; cycle_o=30; counter0=30.
REQ-032 start_i high 5 cycles, low 3 cycles, high 5 cycles, limit_i=0, event_i[1] alternating -> cycle_o=10; counter1=5; counts do not change during the pause.
REQ-033 CNT_W=8, SAT=0, event_i[2]=1 for 257 counting cycles -> counter2=1, ovf_o[2]=1; with SAT=1 -> counter2=255, ovf_o[2]=1.
REQ-034 In DONE, assert clear_i and start_i together -> next edge: state IDLE, all counts 0, ovf_o=0; the following edge enters RUN.
REQ-035 rd_sel_i=3 while counter3 steps 7->8 -> rd_data_o shows 7 one edge later, then 8; rd_sel_i=NUM_EV -> rd_data_o=0.
REQ-036 Pulse rst_i low between clock edges mid-RUN -> all outputs 0 immediately, without waiting for a clock edge; the state is IDLE after release.

Source files
------------

// File: rtl/perf_event_monitor.sv
// Performance event monitor: a run-controlled cycle counter plus NUM_EV event counters
// with wrap/saturate overflow handling, sticky overflow flags and a registered readout.
module perf_event_monitor #(
  parameter int unsigned NUM_EV = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SAT    = 0,
  parameter int unsigned SEL_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [NUM_EV-1:0] event_i,
  input  logic [CNT_W-1:0]  limit_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              running_o,
  output logic              done_o,
  output logic [NUM_EV-1:0] ovf_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] AllOnes = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   cnt_q [NUM_EV];
  logic [CNT_W-1:0]   cnt_d [NUM_EV];
  logic [NUM_EV-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;

  // One step of a counter under the configured overflow rule.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (v == AllOnes) begin
      return (SAT != 0) ? AllOnes : '0;
    end
    return v + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rd_data_d = '0;

    // Readout samples pre-update values; unmatched selects read as zero.
    for (int k = 0; k < int'(NUM_EV); k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rd_data_d = cnt_q[k];
      end
    end

    if (clear_i) begin
      state_d = StIdle;
      cycle_d = '0;
      ovf_d   = '0;
      for (int k = 0; k < int'(NUM_EV); k++) begin
        cnt_d[k] = '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (!start_i) begin
            state_d = StIdle;
          end else begin
            cycle_d = bump(cycle_q);
            for (int k = 0; k < int'(NUM_EV); k++) begin
              if (event_i[k]) begin
                cnt_d[k] = bump(cnt_q[k]);
                if (cnt_q[k] == AllOnes) begin
                  ovf_d[k] = 1'b1;
                end
              end
            end
            // Exact match only: a limit already passed never ends the run.
            if ((limit_i != '0) && (cycle_d == limit_i)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      ovf_q     <= '0;
      rd_data_q <= '0;
      for (int k = 0; k < int'(NUM_EV); k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int k = 0; k < int'(NUM_EV); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign cycle_o   = cycle_q;
  assign ovf_o     = ovf_q;
  assign running_o = (state_q == StRun);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: wrap and saturate instances (CNT_W=8) driven in parallel and
// compared every cycle against a true-count reference model, plus directed literal checks.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear;
  logic [3:0] ev;
  logic [7:0] limit;
  logic [2:0] sel;

  logic [7:0] rd_o  [2];
  logic [7:0] cyc_o [2];
  logic       run_o [2];
  logic       dn_o  [2];
  logic [3:0] ovf_o [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EV(4), .CNT_W(8), .SAT(0), .SEL_W(3)) u_wrap (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .event_i(ev),
    .limit_i(limit), .rd_sel_i(sel), .rd_data_o(rd_o[0]), .cycle_o(cyc_o[0]),
    .running_o(run_o[0]), .done_o(dn_o[0]), .ovf_o(ovf_o[0])
  );

  perf_event_monitor #(.NUM_EV(4), .CNT_W(8), .SAT(1), .SEL_W(3)) u_sat (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .clear_i(clear), .event_i(ev),
    .limit_i(limit), .rd_sel_i(sel), .rd_data_o(rd_o[1]), .cycle_o(cyc_o[1]),
    .running_o(run_o[1]), .done_o(dn_o[1]), .ovf_o(ovf_o[1])
  );

  // Model keeps unbounded true counts; the visible value is derived per overflow mode.
  longint tcnt [2][4] = '{default: 0};
  longint tcyc [2]    = '{default: 0};
  int     st   [2]    = '{default: 0};  // 0 idle, 1 run, 2 done
  longint rd_exp [2]  = '{default: 0};

  function automatic longint shown(input int m, input longint v);
    if (m == 0) return v % 256;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic longint ovf_exp(input int m);
    longint r = 0;
    for (int k = 0; k < 4; k++) if (tcnt[m][k] > 255) r |= (64'd1 << k);
    return r;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        st[m] = 0; tcyc[m] = 0; rd_exp[m] = 0;
        for (int k = 0; k < 4; k++) tcnt[m][k] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        rd_exp[m] = (sel < 4) ? shown(m, tcnt[m][sel]) : 0;
        if (clear) begin
          st[m] = 0; tcyc[m] = 0;
          for (int k = 0; k < 4; k++) tcnt[m][k] = 0;
        end else if (st[m] == 0) begin
          if (start) st[m] = 1;
        end else if (st[m] == 1) begin
          if (!start) st[m] = 0;
          else begin
            tcyc[m]++;
            for (int k = 0; k < 4; k++) if (ev[k]) tcnt[m][k]++;
            if (limit != 0 && shown(m, tcyc[m]) == longint'(limit)) st[m] = 2;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("model_rd[%0d]", m), rd_o[m], rd_exp[m]);
      chk($sformatf("model_cycle[%0d]", m), cyc_o[m], shown(m, tcyc[m]));
      chk($sformatf("model_running[%0d]", m), run_o[m], st[m] == 1);
      chk($sformatf("model_done[%0d]", m), dn_o[m], st[m] == 2);
      chk($sformatf("model_ovf[%0d]", m), ovf_o[m], ovf_exp(m));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; start = 1'b0; ev = '0;
    cyc();
    clear = 1'b0;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; start = 1'b1; clear = 1'b0; limit = 8'd30; ev = 4'b0001; sel = 3'd0;
    chk("reset_cycle", cyc_o[0], 0);
    repeat (2) cyc();
    chk("reset_running", run_o[0], 0);
    chk("reset_rd", rd_o[0], 0);
    #2 rst_n = 1'b1;

    // Run to a 30-cycle limit with event 0 constantly asserted.
    cyc();
    chk("lim_running", run_o[0], 1);
    repeat (29) cyc();
    chk("lim_not_done_29", dn_o[0], 0);
    cyc();
    chk("lim_done", dn_o[0], 1);
    chk("lim_cycle", cyc_o[0], 30);
    cyc();
    chk("lim_cnt0", rd_o[0], 30);

    // Pause and resume: counts hold through the pause.
    do_clear();
    limit = 8'd0; sel = 3'd1; n = 0;
    for (int p = 0; p < 2; p++) begin
      start = 1'b1; ev = '0;
      cyc();
      for (int i = 0; i < 5; i++) begin
        ev = (n % 2 == 0) ? 4'b0010 : 4'b0000;
        n++;
        cyc();
      end
      if (p == 0) begin
        start = 1'b0; ev = 4'b1111;
        repeat (3) cyc();
        chk("pause_cycle_held", cyc_o[0], 5);
      end
    end
    chk("resume_cycle", cyc_o[0], 10);
    start = 1'b0; ev = '0;
    cyc();
    chk("resume_cnt1", rd_o[0], 5);

    // Overflow of counter 2 after 257 events.
    do_clear();
    start = 1'b1; ev = 4'b0100; sel = 3'd2;
    cyc();
    repeat (257) cyc();
    start = 1'b0;
    cyc();
    chk("ovf_wrap_cnt2", rd_o[0], 1);
    chk("ovf_sat_cnt2", rd_o[1], 255);
    chk("ovf_wrap_flag", ovf_o[0], 4'b0100);
    chk("ovf_sat_flag", ovf_o[1], 4'b0100);
    chk("ovf_wrap_cycle", cyc_o[0], 1);
    chk("ovf_sat_cycle", cyc_o[1], 255);

    // Clear wins over start while in DONE.
    do_clear();
    limit = 8'd3; start = 1'b1; ev = 4'b1111;
    cyc();
    repeat (3) cyc();
    chk("clr_in_done", dn_o[0], 1);
    clear = 1'b1;
    cyc();
    chk("clr_done", dn_o[0], 0);
    chk("clr_running", run_o[0], 0);
    chk("clr_cycle", cyc_o[0], 0);
    chk("clr_ovf", ovf_o[1], 0);
    clear = 1'b0;
    cyc();
    chk("clr_restart", run_o[0], 1);

    // Readout latency on counter 3 and out-of-range select.
    do_clear();
    limit = 8'd0; start = 1'b1; ev = 4'b1000; sel = 3'd3;
    cyc();
    repeat (7) cyc();
    cyc();
    chk("rd_7", rd_o[0], 7);
    ev = '0;
    cyc();
    chk("rd_8", rd_o[0], 8);
    sel = 3'd4;
    cyc();
    chk("rd_oob", rd_o[0], 0);

    // Asynchronous reset pulse between edges mid-run.
    sel = 3'd3;
    cyc();
    chk("pre_rst_rd", rd_o[0], 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd", rd_o[0], 0);
    chk("async_cycle", cyc_o[0], 0);
    chk("async_running", run_o[0], 0);
    #3 rst_n = 1'b1;
    chk("post_rst_idle", run_o[0], 0);
    cyc();
    chk("post_rst_run", run_o[0], 1);
    chk("post_rst_cycle", cyc_o[0], 0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 8) != 0;
      clear = ($urandom % 512) == 0;
      ev    = 4'($urandom);
      sel   = 3'($urandom % 8);
      if ($urandom % 16 == 0) limit = ($urandom % 2 == 0) ? 8'd0 : 8'($urandom_range(1, 60));
      if ($urandom % 400 == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
